// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the Memory port-B arbiter and its users.
package mem_arb_pkg;

  localparam int unsigned MEMARB_NREQ_MAX = 8;

  typedef logic [2:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rsp_slot_t;

  localparam req_id_t REQ_UART = 3'd0;
  localparam req_id_t REQ_MEM  = 3'd1;
  localparam req_id_t REQ_DBG  = 3'd2;

  // One-hot decode of a requester id over the maximum requester count
  function automatic logic [MEMARB_NREQ_MAX-1:0] id_onehot(input req_id_t id);
    return MEMARB_NREQ_MAX'(1) << id;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector. Returns the first eligible index at or
// after the pointer, wrapping modulo NREQ (NREQ need not be a power of two).
module rr_picker #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [IdxW-1:0] i_ptr,
  output logic            o_found,
  output logic [IdxW-1:0] o_win
);

  // Scan from the pointer, wrapping by explicit compare against the last index
  always_comb begin
    logic [IdxW-1:0] idx;
    o_found = 1'b0;
    o_win   = i_ptr;
    idx     = i_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_found && i_elig[idx]) begin
        o_found = 1'b1;
        o_win   = idx;
      end
      idx = (idx == IdxW'(NREQ - 1)) ? '0 : idx + IdxW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares Memory port B between NREQ requesters (0 = UART boot loader,
// 1 = MEM stage, 2 = debug/VGA writer). Round-robin with a registered issue stage; read
// data returns RD_LAT cycles after issue and is steered back by requester id. boot_lock
// restricts grants to requester 0. Define MEMARB_PERF_CNT_EN to add per-requester
// saturating grant/wait counters with a select/clear interface.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     boot_lock,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_rdata,
`ifdef MEMARB_PERF_CNT_EN
  input  logic [$clog2(NREQ)-1:0]  perf_sel,
  input  logic                     perf_clr,
  output logic [31:0]              perf_grants,
  output logic [31:0]              perf_waits,
`endif
  output logic                     busy
);

  localparam int unsigned IdxW = $clog2(NREQ);

  logic [NREQ-1:0]   w_elig;
  logic              w_found;
  logic [IdxW-1:0]   w_win;
  logic [NREQ-1:0]   w_win_onehot;
  logic [ADDR_W-1:0] w_slot_addr  [NREQ];
  logic [DATA_W-1:0] w_slot_wdata [NREQ];
  rsp_slot_t         w_last;
  logic              w_pipe_any;

  logic [NREQ-1:0]   r_gnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic [IdxW-1:0]   r_rr_ptr;
  logic [IdxW-1:0]   r_issue_id;
  rsp_slot_t         r_pipe [RD_LAT];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign w_slot_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign w_slot_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // Drop the requester granted this cycle; under boot lock only the boot loader competes
  always_comb begin
    w_elig = req & ~r_gnt;
    if (boot_lock) w_elig = w_elig & NREQ'(id_onehot(REQ_UART));
  end

  rr_picker #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_picker (
    .i_elig  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_win   (w_win)
  );

  assign w_win_onehot = NREQ'(id_onehot(req_id_t'(w_win)));

  // Issue stage: grant pulse and memory command share the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rr_ptr    <= '0;
      r_issue_id  <= '0;
    end else if (w_found) begin
      r_gnt       <= w_win_onehot;
      r_mem_addr  <= w_slot_addr[w_win];
      r_mem_wdata <= w_slot_wdata[w_win];
      r_mem_we    <= req_we[w_win];
      r_rr_ptr    <= (w_win == IdxW'(NREQ - 1)) ? '0 : w_win + IdxW'(1);
      r_issue_id  <= w_win;
    end else begin
      r_gnt    <= '0;
      r_mem_we <= 1'b0;
    end
  end

  // Read-return tracker: stage k holds reads issued k+1 cycles ago
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{valid: (|r_gnt) & ~r_mem_we, id: req_id_t'(r_issue_id)};
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Route memory data to the issuing requester when its read matures
  always_comb begin
    w_last     = r_pipe[RD_LAT-1];
    rvalid     = w_last.valid ? NREQ'(id_onehot(w_last.id)) : '0;
    rdata      = w_last.valid ? mem_rdata : '0;
    w_pipe_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) w_pipe_any = w_pipe_any | r_pipe[i].valid;
  end

  assign gnt       = r_gnt;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign busy      = (|r_gnt) | w_pipe_any;

`ifdef MEMARB_PERF_CNT_EN
  logic [31:0] r_perf_grants [NREQ];
  logic [31:0] r_perf_waits  [NREQ];

  // Saturating per-requester counts of grants and of requesting-but-not-granted cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        r_perf_grants[i] <= '0;
        r_perf_waits[i]  <= '0;
      end
    end else if (perf_clr) begin
      for (int i = 0; i < NREQ; i++) begin
        r_perf_grants[i] <= '0;
        r_perf_waits[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_gnt[i] && (r_perf_grants[i] != '1)) r_perf_grants[i] <= r_perf_grants[i] + 32'd1;
        if (req[i] && !r_gnt[i] && (r_perf_waits[i] != '1)) begin
          r_perf_waits[i] <= r_perf_waits[i] + 32'd1;
        end
      end
    end
  end

  assign perf_grants = (32'(perf_sel) < NREQ) ? r_perf_grants[perf_sel] : '0;
  assign perf_waits  = (32'(perf_sel) < NREQ) ? r_perf_waits[perf_sel]  : '0;
`endif

endmodule
